// File: rtl/parshift_rx_if.sv
// Word-level link between the serial receiver and its neighbours: framing inputs
// from the transmitter and the held-word valid/ack handshake toward the consumer.
interface parshift_rx_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sin;
    logic             last;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             dack;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    // master: transmitter + consumer side; slave: the receiver itself
    modport master (
        output start, sin, last, dack,
        input  dout, dvalid, busy, frame_err, overrun
    );

    modport slave (
        input  start, sin, last, dack,
        output dout, dvalid, busy, frame_err, overrun
    );
endinterface

// File: rtl/parshift_rx.sv
// Serial-in, parallel-out receiver: assembles MSB-first WIDTH-bit words framed by the
// transmitter's load strobe and done flag, and holds each word behind valid/ack.
module parshift_rx #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    parshift_rx_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > 127) begin : g_bad_width
        $error("parshift_rx: WIDTH must be in 2..127");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(WIDTH - 1);

    state_t           state,     state_nxt;
    logic [6:0]       bitcnt,    bitcnt_nxt;
    logic [WIDTH-1:0] shreg,     shreg_nxt;
    logic [WIDTH-1:0] dout,      dout_nxt;
    logic             dvalid,    dvalid_nxt;
    logic             frame_err, frame_err_nxt;
    logic             overrun,   overrun_nxt;
    logic             complete;

    // NOTE: every next-value gets a default before the case so no path leaves a
    // variable unassigned; otherwise synthesis infers a latch to hold it.
    always_comb begin
        state_nxt     = state;
        bitcnt_nxt    = bitcnt;
        shreg_nxt     = shreg;
        dout_nxt      = dout;
        dvalid_nxt    = dvalid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = overrun;
        complete      = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = SHIFT;
                    bitcnt_nxt = '0;
                end
            end

            SHIFT: begin
                shreg_nxt = {shreg[WIDTH-2:0], bus.sin};
                if (bitcnt < LAST_IDX) begin
                    // A fresh load strobe beats a premature done flag: re-arm on it.
                    if (bus.start) begin
                        frame_err_nxt = 1'b1;
                        bitcnt_nxt    = '0;
                    end else if (bus.last) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        bitcnt_nxt = bitcnt + 7'd1;
                    end
                end else begin
                    if (!bus.last) begin
                        frame_err_nxt = 1'b1;
                    end else if (!dvalid || bus.dack) begin
                        dout_nxt = shreg_nxt;
                        complete = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                    bitcnt_nxt = '0;
                    state_nxt  = bus.start ? SHIFT : IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        // A completion on the ack edge refills the register, so dvalid stays high.
        if (complete) begin
            dvalid_nxt = 1'b1;
        end else if (dvalid && bus.dack) begin
            dvalid_nxt = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            dout      <= '0;
            dvalid    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            dout      <= dout_nxt;
            dvalid    <= dvalid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    assign bus.dout      = dout;
    assign bus.dvalid    = dvalid;
    assign bus.busy      = (state == SHIFT);
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;

endmodule

// File: doc/parshift_rx.md
# parshift_rx

Serial-in, parallel-out receiver for the MSB-first serial stream produced by the team's synchronous parallel-load shift register transmitter. It runs on the same clock as the transmitter and uses the transmitter's load strobe and done flag for framing. It assembles WIDTH-bit words, checks framing, and presents each word on a held output register with a valid/ack handshake. It sits at the far end of the serial link, feeding counter/capture logic that consumes whole words.

## Interface
- WIDTH, 32, word length in bits; legal range 2..127
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame strobe; the transmitter's load, seen on the same edge the transmitter loads
- sin  in  1  serial data, MSB first; the transmitter's sout
- last  in  1  the transmitter's done flag; high while bit 0 is on sin
- dout  out  WIDTH  last accepted word; held until replaced
- dvalid  out  1  dout holds an unconsumed word
- dack  in  1  consumer takes dout on an edge where dvalid&dack
- busy  out  1  frame in progress (state SHIFT)
- frame_err  out  1  one-cycle pulse on a discarded or aborted frame
- overrun  out  1  sticky; a completed word was dropped because dvalid was still high

## Operation
- State machine has two states, IDLE and SHIFT. Internal registers: shreg[WIDTH-1:0] and a 7-bit bitcnt.
- Reset (async) sets: state=IDLE, bitcnt=0, shreg=0, dout=0, dvalid=0, frame_err=0, overrun=0. busy is 0 after reset.
- IDLE, start=1 → go to SHIFT, bitcnt=0. sin is ignored on this edge.
- IDLE, start=0 → stay in IDLE; sin and last are ignored.
- SHIFT, each edge:
  - shreg={shreg[WIDTH-2:0], sin}.
  - bitcnt is the index of the bit being sampled, counted from the MSB (0 = MSB).
- SHIFT, bitcnt<WIDTH-1:
  - If start=1, the frame is aborted: frame_err pulses, bitcnt=0, stay in SHIFT (re-arm).
  - Else if last=1 (done flag too early), frame_err pulses and state goes to IDLE.
  - Else bitcnt increments.
- SHIFT, bitcnt==WIDTH-1 (final bit, b0):
  - Candidate word is {shreg[WIDTH-2:0], sin}.
  - If last=0, the word is discarded and frame_err pulses.
  - If last=1, the word completes:
    - dvalid=0, or dack=1 on the same edge → dout=word, dvalid=1.
    - Otherwise the word is dropped, dout and dvalid are unchanged, and overrun is set.
  - Next state: start=1 → SHIFT with bitcnt=0 (back-to-back frame, no gap); start=0 → IDLE.
- Handshake:
  - dvalid&dack with no completion on that edge → dvalid=0.
  - dack while dvalid=0 is ignored.
  - dout is never cleared except by reset.
- overrun and frame_err are independent. overrun clears only on rst.

## Timing
- Frame alignment: transmitter load at edge E0. The receiver samples MSB at E1 and b0 at E_WIDTH. last must be high exactly at E_WIDTH.
- Latency: dout/dvalid update at E_WIDTH, visible in the cycle after the b0 sample. This is WIDTH edges after start.
- Throughput: one word per WIDTH cycles, with start re-asserted at E_WIDTH.
- busy=1 from the edge after start through the b0 edge. busy=0 after a non-restarting completion.
- frame_err is high for exactly one cycle after the offending edge.
- rst asserted mid-frame: outputs go to reset values immediately. The partial word is lost, and no frame_err is raised.

## Test plan
- WIDTH=8, transmitter loads 0xA5, dack held 1 → dout=0xA5, dvalid rises 8 edges after start, busy high for 8 cycles, no errors.
- Back-to-back 0x3C then 0xC3 with start at E0 and E8, dack=1 → dout=0x3C at E8, then 0xC3 at E16, no gap, no frame_err.
- Two words completed with dack=0 → dout=first word, dvalid=1, overrun=1. Then dack pulse → dvalid=0, overrun stays 1 until rst.
- start re-asserted at bitcnt=3, then a full frame of 0x81 → one frame_err pulse at the abort, then dout=0x81.
- last forced high at bitcnt=5 → frame_err pulse, busy=0, dout/dvalid unchanged. Separately, last=0 at b0 → frame_err, no dvalid.
- Completion edge with dvalid=1 and dack=1 simultaneously → dout replaced, dvalid stays 1, overrun stays 0. Then rst mid-frame → all outputs 0.
